// File: rtl/reg_xfer_pkg.sv
// rtl/reg_xfer_pkg.sv - shared FSM encoding and size defaults for the register transfer controller
package reg_xfer_pkg;

  localparam int NREG_DEFAULT = 4;
  localparam int NREQ_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_DRIVE = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, one-hot grant, pointer advances on accept
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // ptr_q = 1 gives requester 1 priority; it points away from the last winner
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!ptr_q || !req_i[1])) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// rtl/reg_xfer_ctrl.sv - arbitrated register-to-register transfer sequencer on a shared bus
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         Req,
  input  logic [$clog2(NREG)-1:0] Src0,
  input  logic [$clog2(NREG)-1:0] Src1,
  input  logic [$clog2(NREG)-1:0] Dst0,
  input  logic [$clog2(NREG)-1:0] Dst1,
  output logic [NREQ-1:0]         Gnt,
  output logic [NREQ-1:0]         Done,
  output logic [$clog2(NREG)-1:0] Bus_Sel,
  output logic [NREG-1:0]         Reg_En,
  output logic                    Busy
);

  localparam int SW = $clog2(NREG);

  xfer_state_e      state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [SW-1:0]    bus_sel_q, bus_sel_d;
  logic [NREG-1:0]  reg_en_q, reg_en_d;
  logic             busy_q, busy_d;
  logic [SW-1:0]    src_q, src_d;
  logic [SW-1:0]    dst_q, dst_d;
  logic             accept;
  logic [1:0]       arb_gnt;

  rr_arb2 u_arb (
    .clk_i    (Clock),
    .rst_ni   (Reset),
    .req_i    (Req[1:0]),
    .accept_i (accept),
    .gnt_o    (arb_gnt)
  );

  // Every output is computed one state ahead and flopped, so nothing leaks from Req/Src/Dst
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    reg_en_d  = '0;
    bus_sel_d = bus_sel_q;
    src_d     = src_q;
    dst_d     = dst_q;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|Req) begin
          state_d = ST_GRANT;
          accept  = 1'b1;
          gnt_d   = arb_gnt;
          src_d   = arb_gnt[1] ? Src1 : Src0;
          dst_d   = arb_gnt[1] ? Dst1 : Dst0;
        end
      end
      ST_GRANT: begin
        state_d   = ST_DRIVE;
        bus_sel_d = src_q;
      end
      ST_DRIVE: begin
        state_d         = ST_LOAD;
        bus_sel_d       = src_q;
        reg_en_d[dst_q] = 1'b1;
      end
      ST_LOAD: begin
        state_d = ST_DONE;
        done_d  = gnt_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      bus_sel_q <= '0;
      reg_en_q  <= '0;
      busy_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      bus_sel_q <= bus_sel_d;
      reg_en_q  <= reg_en_d;
      busy_q    <= busy_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
    end
  end

  assign Gnt     = gnt_q;
  assign Done    = done_q;
  assign Bus_Sel = bus_sel_q;
  assign Reg_En  = reg_en_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb/tb_reg_xfer_ctrl.sv - directed scoreboard bench for reg_xfer_ctrl
module tb_reg_xfer_ctrl;

  logic       Clock;
  logic       Reset;
  logic [1:0] Req;
  logic [1:0] Src0, Src1, Dst0, Dst1;
  logic [1:0] Gnt, Done, Bus_Sel;
  logic [3:0] Reg_En;
  logic       Busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] gnt;
    logic [1:0] src;
    logic [1:0] dst;
  } xfer_t;

  xfer_t sb[$];

  logic [3:0] cap_en;
  logic [1:0] cap_sel;
  logic [1:0] cap_gnt;
  logic       cap_valid = 1'b0;

  reg_xfer_ctrl #(.NREG(4), .NREQ(2)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req     (Req),
    .Src0    (Src0),
    .Src1    (Src1),
    .Dst0    (Dst0),
    .Dst1    (Dst1),
    .Gnt     (Gnt),
    .Done    (Done),
    .Bus_Sel (Bus_Sel),
    .Reg_En  (Reg_En),
    .Busy    (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [1:0] g, input logic [1:0] s, input logic [1:0] d);
    xfer_t e;
    e.gnt = g;
    e.src = s;
    e.dst = d;
    sb.push_back(e);
  endtask

  // Completion monitor: capture the load cycle, score it when Done arrives
  always @(negedge Clock) begin
    if (!Reset) begin
      cap_valid = 1'b0;
    end else begin
      if (Reg_En != 4'b0000) begin
        chk("reg_en_onehot", 32'($countones(Reg_En)), 32'd1);
        cap_en    = Reg_En;
        cap_sel   = Bus_Sel;
        cap_gnt   = Gnt;
        cap_valid = 1'b1;
      end
      if (Done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(Done), 32'd0);
        end else begin
          xfer_t e;
          e = sb.pop_front();
          chk("sb_done",     32'(Done),      32'(e.gnt));
          chk("sb_loaded",   32'(cap_valid), 32'd1);
          chk("sb_reg_en",   32'(cap_en),    32'(4'b0001 << e.dst));
          chk("sb_bus_sel",  32'(cap_sel),   32'(e.src));
          chk("sb_gnt_load", 32'(cap_gnt),   32'(e.gnt));
        end
        cap_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, d1, ndone, ngrant, n0, n1;
    logic [1:0] prev_gnt;
    Reset = 1'b0;
    Req = 2'b00; Src0 = 2'd0; Src1 = 2'd0; Dst0 = 2'd0; Dst1 = 2'd0;
    tick(); tick();
    chk("rst_gnt",  32'(Gnt),     32'd0);
    chk("rst_done", 32'(Done),    32'd0);
    chk("rst_en",   32'(Reg_En),  32'd0);
    chk("rst_sel",  32'(Bus_Sel), 32'd0);
    chk("rst_busy", 32'(Busy),    32'd0);
    Reset = 1'b1;
    tick();

    // Single transfer, Req dropped right after GRANT
    Req = 2'b01; Src0 = 2'd2; Dst0 = 2'd1;
    push(2'b01, 2'd2, 2'd1);
    tick();
    chk("s_gnt_grant", 32'(Gnt), 32'b01);
    chk("s_busy",      32'(Busy), 32'd1);
    chk("s_en_grant",  32'(Reg_En), 32'd0);
    Req = 2'b00;
    tick();
    chk("s_sel_drive", 32'(Bus_Sel), 32'd2);
    chk("s_en_drive",  32'(Reg_En), 32'd0);
    tick();
    chk("s_sel_load",  32'(Bus_Sel), 32'd2);
    chk("s_en_load",   32'(Reg_En), 32'b0010);
    chk("s_done_load", 32'(Done), 32'd0);
    tick();
    chk("s_done",      32'(Done), 32'b01);
    chk("s_en_done",   32'(Reg_En), 32'd0);
    chk("s_gnt_done",  32'(Gnt), 32'b01);
    tick();
    chk("s_idle_busy", 32'(Busy), 32'd0);
    chk("s_idle_gnt",  32'(Gnt), 32'd0);
    chk("s_idle_done", 32'(Done), 32'd0);

    // Operand stability: Src/Dst change during DRIVE
    Req = 2'b01; Src0 = 2'd2; Dst0 = 2'd3;
    push(2'b01, 2'd2, 2'd3);
    tick();
    Req = 2'b00;
    tick();
    Src0 = 2'd3; Dst0 = 2'd0;
    chk("op_sel_drive", 32'(Bus_Sel), 32'd2);
    tick();
    chk("op_sel_load", 32'(Bus_Sel), 32'd2);
    chk("op_en_load",  32'(Reg_En), 32'b1000);
    tick(); tick();

    // Src == Dst
    Req = 2'b01; Src0 = 2'd1; Dst0 = 2'd1;
    push(2'b01, 2'd1, 2'd1);
    tick();
    Req = 2'b00;
    tick(); tick();
    chk("eq_en", 32'(Reg_En), 32'b0010);
    tick();
    chk("eq_done", 32'(Done), 32'b01);
    tick();

    // Reset mid-DRIVE: outputs clear at once, no pulses follow
    Req = 2'b01; Src0 = 2'd1; Dst0 = 2'd2;
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("ar_gnt",  32'(Gnt),     32'd0);
    chk("ar_sel",  32'(Bus_Sel), 32'd0);
    chk("ar_en",   32'(Reg_En),  32'd0);
    chk("ar_busy", 32'(Busy),    32'd0);
    chk("ar_done", 32'(Done),    32'd0);
    Req = 2'b00;
    tick(); tick();
    Reset = 1'b1;
    tick(); tick(); tick(); tick();
    chk("ar_idle_busy", 32'(Busy), 32'd0);
    chk("ar_idle_gnt",  32'(Gnt),  32'd0);

    // Contention: requester 0 first after reset, Done pulses five apart
    Req = 2'b11; Src0 = 2'd0; Dst0 = 2'd3; Src1 = 2'd1; Dst1 = 2'd2;
    push(2'b01, 2'd0, 2'd3);
    push(2'b10, 2'd1, 2'd2);
    d0 = -1; d1 = -1; ndone = 0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      tick();
      if (Gnt == 2'b10) Req = 2'b00;
      if (Done != 2'b00) begin
        if (ndone == 0) d0 = i; else d1 = i;
        ndone++;
      end
    end
    chk("ct_ndone", 32'(ndone), 32'd2);
    chk("ct_first_done_cycle", 32'(d0), 32'd3);
    chk("ct_spacing", 32'(d1 - d0), 32'd5);
    tick(); tick();

    // Fairness: 20 transfers with both requesting
    Src0 = 2'd3; Dst0 = 2'd0; Src1 = 2'd2; Dst1 = 2'd1;
    for (int k = 0; k < 10; k++) begin
      push(2'b01, 2'd3, 2'd0);
      push(2'b10, 2'd2, 2'd1);
    end
    Req = 2'b11;
    ngrant = 0; ndone = 0; n0 = 0; n1 = 0; prev_gnt = 2'b00;
    for (int i = 0; i < 300 && ndone < 20; i++) begin
      tick();
      if (Gnt != 2'b00 && prev_gnt == 2'b00) begin
        ngrant++;
        if (ngrant == 20) Req = 2'b00;
      end
      prev_gnt = Gnt;
      if (Done == 2'b01) n0++;
      if (Done == 2'b10) n1++;
      if (Done != 2'b00) ndone++;
    end
    chk("fair_done", 32'(ndone), 32'd20);
    chk("fair_req0", 32'(n0), 32'd10);
    chk("fair_req1", 32'(n1), 32'd10);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("fair_idle", 32'(Busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_xfer_ctrl.md
REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 4, number of 32-bit registers on the shared transfer bus (power of two, 2..8).
REQ-002 SHALL have parameter NREQ, default 2, number of transfer requesters (fixed at 2 in this revision).
REQ-003 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Req, input, NREQ, per-requester transfer request level.
REQ-006 SHALL have port Src0 / Src1, input, log2(NREG) each, source register index per requester.
REQ-007 SHALL have port Dst0 / Dst1, input, log2(NREG) each, destination register index per requester.
REQ-008 SHALL have port Gnt, output, NREQ, one-hot grant, held for the whole transfer.
REQ-009 SHALL have port Done, output, NREQ, one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port Bus_Sel, output, log2(NREG), mux select putting the source register's output on the shared bus.
REQ-011 SHALL have port Reg_En, output, NREG, one-hot load enable to the registers' En inputs.
REQ-012 SHALL have port Busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, DRIVE, LOAD, DONE.
REQ-014 IDLE -> GRANT when any Req bit is high; otherwise stay in IDLE.
REQ-015 In GRANT: choose one requester by round-robin, priority to the requester not served last; after reset requester 0 has priority.
REQ-016 In GRANT: latch the winner's Src/Dst into internal registers; later changes on Src/Dst have no effect until the next GRANT.
REQ-017 GRANT -> DRIVE unconditionally: Bus_Sel = latched Src, Reg_En = 0.
REQ-018 DRIVE -> LOAD: Bus_Sel holds latched Src, Reg_En[latched Dst] = 1 for exactly one cycle.
REQ-019 LOAD -> DONE: Done[winner] = 1 for one cycle, Reg_En = 0.
REQ-020 DONE -> IDLE; IDLE -> GRANT costs one cycle, so Req-high to Done pulse is 4 cycles and back-to-back transfers take 5 cycles each.
REQ-021 Gnt SHALL be one-hot from GRANT through DONE and zero in IDLE.
REQ-022 All outputs SHALL be registered, with no combinational path from Req, Src or Dst to any output.
REQ-023 When Src == Dst, the sequence SHALL run unchanged: the register reloads its own value.
REQ-024 If the winner drops Req after GRANT, the transfer SHALL still complete with Done asserted.
REQ-025 If both Req bits are high at GRANT, the loser SHALL wait with Gnt low; it wins the next GRANT if still requesting.
REQ-026 Reg_En SHALL never have more than one bit high, and SHALL be zero outside LOAD.

Reset
REQ-027 Reset low SHALL immediately force state IDLE, Gnt=0, Done=0, Reg_En=0, Bus_Sel=0, Busy=0, round-robin pointer to requester 0, and latched Src/Dst=0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no Reg_En pulse and no Done pulse; the first transfer after Reset rises follows REQ-014.

Structure
REQ-029 FSM state encoding and the NREG/NREQ defaults SHALL live in a shared package, reg_xfer_pkg.
REQ-030 Arbitration SHALL be a sub-module, rr_arb2 (2-input round-robin arbiter with a one-hot grant and pointer update on accept).

Verification
REQ-031 Reset test: Reset=0 asserted mid-DRIVE -> all outputs 0 in the same cycle, no Reg_En or Done pulse follows, state IDLE after release.
REQ-032 Single transfer: Req=01, Src0=2, Dst0=1 -> Gnt=01 in GRANT, Bus_Sel=2 in DRIVE and LOAD, Reg_En=0010 for one cycle, Done=01 four cycles after Req.
REQ-033 Contention: Req=11 held with Src0=0/Dst0=3 and Src1=1/Dst1=2 -> requester 0 served first (Reg_En=1000), then requester 1 (Reg_En=0100), Done pulses five cycles apart.
REQ-034 Fairness: Req=11 held for 20 transfers -> Gnt alternates 01,10,...; each requester served 10 times.
REQ-035 Operand stability: change Src0 from 2 to 3 during DRIVE -> Bus_Sel stays 2, Reg_En targets the latched Dst.
REQ-036 Edge cases: Src0=Dst0=1 -> Reg_En=0010 and Done=01 as normal; Req dropped after GRANT -> Done still pulses.
